// File: rtl/reg_op_sequencer_if.sv
// Command handshake between a host and the register micro-op sequencer.
// The host owns valid/op/arg/abort; the sequencer answers with ready.
interface reg_op_sequencer_if #(
   parameter int W = 4
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_arg;
   logic         abort;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, abort,
      output cmd_ready
   );
endinterface

// File: rtl/reg_op_sequencer.sv
// Expands one command into the picoComputer register's one-hot control strobes,
// using the register output as feedback for serial-in bits and the status flag.
module reg_op_sequencer #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   reg_op_sequencer_if.slave cmd,
   input  logic [W-1:0] reg_q_i,
   output logic         reg_cl_o,
   output logic         reg_ld_o,
   output logic         reg_inc_o,
   output logic         reg_dec_o,
   output logic         reg_sr_o,
   output logic         reg_sl_o,
   output logic [W-1:0] reg_in_o,
   output logic         reg_ir_o,
   output logic         reg_il_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         aborted_o,
   output logic         flag_o
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_CLR  = 3'd1,
      OP_LOAD = 3'd2,
      OP_ADD  = 3'd3,
      OP_SUB  = 3'd4,
      OP_SHR  = 3'd5,
      OP_SHL  = 3'd6,
      OP_ROR  = 3'd7
   } opcode_e;

   state_e       state_q, state_d;
   opcode_e      op_q, op_d;
   logic [W-1:0] arg_q, arg_d;
   logic [W-1:0] remaining_q, remaining_d;
   logic         flag_q, flag_d;
   logic         aborted_q, aborted_d;
   logic         strobeEn;
   logic         stepFlag;
   logic [W-1:0] acceptCount;

   function automatic logic [W-1:0] strobeCount(opcode_e op, logic [W-1:0] arg);
      case (op)
         OP_NOP:           strobeCount = '0;
         OP_CLR, OP_LOAD:  strobeCount = W'(1);
         default:          strobeCount = arg;
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         arg_q       <= '0;
         remaining_q <= '0;
         flag_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         arg_q       <= arg_d;
         remaining_q <= remaining_d;
         flag_q      <= flag_d;
         aborted_q   <= aborted_d;
      end
   end

   // Flag value after the current strobe; ADD/SUB accumulate, shifts track the last bit out.
   always_comb begin
      stepFlag = 1'b0;
      case (op_q)
         OP_ADD:         stepFlag = flag_q | (reg_q_i == {W{1'b1}});
         OP_SUB:         stepFlag = flag_q | (reg_q_i == '0);
         OP_SHR, OP_ROR: stepFlag = reg_q_i[0];
         OP_SHL:         stepFlag = reg_q_i[W-1];
         default:        stepFlag = 1'b0;
      endcase
   end

   assign acceptCount = strobeCount(opcode_e'(cmd.cmd_op), cmd.cmd_arg);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      arg_d       = arg_q;
      remaining_d = remaining_q;
      flag_d      = flag_q;
      aborted_d   = aborted_q;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               op_d        = opcode_e'(cmd.cmd_op);
               arg_d       = cmd.cmd_arg;
               remaining_d = acceptCount;
               flag_d      = 1'b0;
               aborted_d   = 1'b0;
               state_d     = (acceptCount == '0) ? DONE : EXEC;
            end
         end
         EXEC: begin
            if (cmd.abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else begin
               flag_d      = stepFlag;
               remaining_d = remaining_q - W'(1);
               if (remaining_q == W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Abort and reset both suppress the strobe in the very cycle they are seen.
   assign strobeEn = (state_q == EXEC) && !cmd.abort && !rst_i;

   always_comb begin
      reg_cl_o  = 1'b0;
      reg_ld_o  = 1'b0;
      reg_inc_o = 1'b0;
      reg_dec_o = 1'b0;
      reg_sr_o  = 1'b0;
      reg_sl_o  = 1'b0;
      reg_ir_o  = 1'b0;
      if (strobeEn) begin
         case (op_q)
            OP_CLR:  reg_cl_o  = 1'b1;
            OP_LOAD: reg_ld_o  = 1'b1;
            OP_ADD:  reg_inc_o = 1'b1;
            OP_SUB:  reg_dec_o = 1'b1;
            OP_SHR:  reg_sr_o  = 1'b1;
            OP_SHL:  reg_sl_o  = 1'b1;
            OP_ROR: begin
               reg_sr_o = 1'b1;
               reg_ir_o = reg_q_i[0];
            end
            default: ;
         endcase
      end
   end

   assign reg_in_o      = arg_q;
   assign reg_il_o      = 1'b0;
   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);
   assign aborted_o     = aborted_q;
   assign flag_o        = flag_q;

endmodule
